// File: rtl/led_fade_driver.sv
// led_fade_driver: per-channel 8-bit PWM output stage for the flow-LED shifter.
// An active channel jumps to full brightness. An inactive channel decays
// linearly to off on each fade tick, which leaves a fading trail behind
// the running light.
module led_fade_driver #(
    parameter logic [24:0] FADE_DIV  = 25'd124_999,
    parameter logic [7:0]  FADE_STEP = 8'd4
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [3:0] led_in,
    output logic [3:0] led_out
);

    localparam logic [7:0] DUTY_FULL = 8'hFF;

    logic [3:0]  led_q,      led_d;
    logic [7:0]  pwm_cnt_q,  pwm_cnt_d;
    logic [24:0] fade_cnt_q, fade_cnt_d;
    logic [7:0]  duty_q [4];
    logic [7:0]  duty_d [4];
    logic [3:0]  led_out_q,  led_out_d;
    logic        fade_tick;

    // One-clock strobe at the end of each fade period.
    assign fade_tick = (fade_cnt_q == FADE_DIV);
    assign led_out   = led_out_q;

    // Input register plus the shared counters. Both counters free-run and
    // ignore LED activity.
    always_comb begin
        led_d      = led_in;
        pwm_cnt_d  = pwm_cnt_q + 8'd1;
        fade_cnt_d = fade_tick ? 25'd0 : fade_cnt_q + 25'd1;
    end

    // Duty update: load wins over decay, and decay saturates at zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            // NOTE: every path starts from a default so the hold case cannot infer a latch.
            duty_d[i] = duty_q[i];
            if (led_q[i]) begin
                duty_d[i] = DUTY_FULL;
            end else if (fade_tick) begin
                duty_d[i] = (duty_q[i] < FADE_STEP) ? 8'd0 : duty_q[i] - FADE_STEP;
            end
        end
    end

    // PWM compare. Full duty is forced on so there is no one-clock dip per frame.
    always_comb begin
        led_out_d = '0;
        for (int i = 0; i < 4; i++) begin
            led_out_d[i] = (duty_q[i] == DUTY_FULL) || (pwm_cnt_q < duty_q[i]);
        end
    end

    // State register. An asynchronous reset discards all fade state at once.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q      <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            led_out_q  <= '0;
            // NOTE: the duty array is reset as well, because a fade must not survive a reset.
            for (int i = 0; i < 4; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values.
            led_q      <= led_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            led_out_q  <= led_out_d;
            for (int i = 0; i < 4; i++) begin
                duty_q[i] <= duty_d[i];
            end
        end
    end

endmodule
